module_fsm_alu: RTL

Parametrised, handshaked arithmetic controller: the next generation of the switch-driven sum FSM. It captures two WIDTH-bit operands on a rising edge of `start` and executes one of four operations: add, subtract, accumulate, or clear accumulator. It registers a WIDTH+1-bit result with an overflow flag and pulses `done`. It sits between the dipswitch/button input conditioning and the hex/7-segment display path.

---
 rtl/module_fsm_alu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/module_fsm_alu.sv
// module_fsm_alu: handshaked add/sub/accumulate/clear controller.
// Ports: clk, rst (async low), start, op, num_a, num_b -> result, ovf, busy, done, state.
// Optional build macro FSM_ALU_SAT_EN: accumulate saturates instead of wrapping.
module module_fsm_alu #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num_a,
  input  logic [WIDTH-1:0] num_b,
  output logic [WIDTH:0]   result,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] EXEC   = 2'b01;
  localparam logic [1:0] FINISH = 2'b10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [1:0]       state_q;
  logic [1:0]       next_state;
  logic             start_q;
  logic             trig;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH:0]   acc_q;

  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic             borrow;
  logic [WIDTH+1:0] acc_sum;
  logic             acc_carry;

  logic [WIDTH:0]   alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   acc_nxt;
  logic             acc_we;

  logic is_add;
  logic is_sub;
  logic is_acc;
  logic is_clr;

  // Rising edge only; start_q resets high so a level held
  // through reset release is not seen as an edge.
  assign trig = start & ~start_q;

  always_comb begin
    next_state = IDLE;
    unique case (state_q)
      IDLE:    next_state = trig ? EXEC : IDLE;
      EXEC:    next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign is_add = (op_q == OP_ADD);
  assign is_sub = (op_q == OP_SUB);
  assign is_acc = (op_q == OP_ACC);
  assign is_clr = (op_q == OP_CLR);

  // WIDTH+1 bits hold any A+B, so add never overflows.
  assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ab = {1'b0, a_q} - {1'b0, b_q};
  assign borrow  = (a_q < b_q);

  // One extra bit above acc width exposes the carry-out.
  assign acc_sum   = {1'b0, acc_q} + {2'b00, a_q};
  assign acc_carry = acc_sum[WIDTH+1];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    acc_nxt = acc_q;
    acc_we  = 1'b0;
    unique case (1'b1)
      is_add: begin
        alu_res = sum_ab;
        alu_ovf = 1'b0;
      end
      is_sub: begin
        alu_res = diff_ab;
        alu_ovf = borrow;
      end
      is_acc: begin
        acc_we  = 1'b1;
`ifdef FSM_ALU_SAT_EN
        acc_nxt = acc_carry ? '1 : acc_sum[WIDTH:0];
`else
        acc_nxt = acc_sum[WIDTH:0];
`endif
        alu_res = acc_nxt;
        alu_ovf = acc_carry;
      end
      is_clr: begin
        acc_we  = 1'b1;
        acc_nxt = '0;
        alu_res = '0;
        alu_ovf = 1'b0;
      end
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      acc_q   <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= next_state;
      start_q <= start;
      busy    <= (next_state != IDLE);
      done    <= (state_q == EXEC);
      if (state_q == IDLE && trig) begin
        a_q  <= num_a;
        b_q  <= num_b;
        op_q <= op;
      end
      if (state_q == EXEC) begin
        result <= alu_res;
        ovf    <= alu_ovf;
        if (acc_we) begin
          acc_q <= acc_nxt;
        end
      end
    end
  end

  assign state = state_q;

endmodule
